light_arbiter_ctrl: RTL and testbench

- Shared-light controller that sequences one lamp output from N independent wall switches, as in a multi-way staircase installation.
- Each raw switch input is synchronized and edge-detected, then held in a pending register so no press is lost.
- Pending presses are granted one per cycle in round-robin order; each grant drives an OFF/ON/WARN state machine with an optional auto-off timer.
- Sits between the raw button pins and the lamp driver, replacing per-switch toggle logic.

---
 rtl/light_arbiter_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_light_arbiter_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_arbiter_ctrl.sv
// light_arbiter_ctrl: one lamp shared by N wall switches (multi-way staircase).
// Every raw switch level is synchronized and edge-detected. Each detected press
// is held in a pending bit until a round-robin arbiter grants it (one grant per
// cycle). Each grant is one event for the OFF/ON/WARN lamp state machine.
// Build option LIGHT_ARB_AUTO_OFF_EN: when defined, an auto-off timer with a
// WARN phase is present. When undefined, grants only toggle the lamp between
// OFF and ON, and warn is tied low.
module light_arbiter_ctrl #(
  parameter int N        = 4,
  parameter int TIMEOUT  = 1000,
  parameter int WARN_CYC = 100,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic         light,
  output logic         warn,
  output logic [N-1:0] grant,
  output logic [2:0]   owner,
  output logic [N-1:0] pend
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_WARN = 2'd2
  } state_e;

  logic [N-1:0] s1_q, s2_q, s3_q;
  logic [N-1:0] edge_s;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] gnt_s, grant_q;
  logic [2:0]   ptr_q, ptr_d, owner_q;
  logic [2:0]   idx_hi_s, idx_lo_s, gnt_idx_s;
  logic         hit_hi_s, hit_lo_s, gnt_vld_s;
  state_e       state_q;
  logic         light_q;
`ifdef LIGHT_ARB_AUTO_OFF_EN
  logic             warn_q;
  logic [CNT_W-1:0] timer_q;
`endif

  // Reject parameter sets the timer and the owner field cannot represent.
  generate
    if ((N < 2) || (N > 8) || (TIMEOUT <= WARN_CYC) || (TIMEOUT >= (1 << CNT_W))) begin : g_bad_cfg
      $error("light_arbiter_ctrl: illegal parameter set");
    end
  endgenerate

  // Detect a press: s2 is high now and was low one sample earlier (held level gives one edge).
  assign edge_s = s2_q & ~s3_q;

  // Round-robin search: the first pending bit at or above ptr wins; otherwise wrap to the lowest set bit.
  always_comb begin
    hit_hi_s = 1'b0;
    hit_lo_s = 1'b0;
    idx_hi_s = 3'd0;
    idx_lo_s = 3'd0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i] && !hit_hi_s && (i >= int'(ptr_q))) begin
        hit_hi_s = 1'b1;
        idx_hi_s = 3'(i);
      end else begin
        hit_hi_s = hit_hi_s;
      end
      if (pend_q[i] && !hit_lo_s) begin
        hit_lo_s = 1'b1;
        idx_lo_s = 3'(i);
      end else begin
        hit_lo_s = hit_lo_s;
      end
    end
    gnt_vld_s = hit_lo_s;
    gnt_idx_s = hit_hi_s ? idx_hi_s : idx_lo_s;
  end

  // Grant vector, next pointer, and pending update. A new edge wins over the grant clear.
  always_comb begin
    gnt_s = {N{1'b0}};
    ptr_d = ptr_q;
    if (gnt_vld_s) begin
      gnt_s = {{(N-1){1'b0}}, 1'b1} << gnt_idx_s;
      if (gnt_idx_s == 3'(N-1)) begin
        ptr_d = 3'd0;
      end else begin
        ptr_d = gnt_idx_s + 3'd1;
      end
    end else begin
      ptr_d = ptr_q;
    end
    pend_d = (pend_q & ~gnt_s) | edge_s;
  end

  // Synchronizer chain, pending requests, arbitration pointer and registered grant/owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= {N{1'b0}};
      s2_q    <= {N{1'b0}};
      s3_q    <= {N{1'b0}};
      pend_q  <= {N{1'b0}};
      grant_q <= {N{1'b0}};
      ptr_q   <= 3'd0;
      owner_q <= 3'd0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pend_q  <= pend_d;
      grant_q <= gnt_s;
      ptr_q   <= ptr_d;
      if (gnt_vld_s) begin
        owner_q <= gnt_idx_s;
      end
    end
  end

`ifdef LIGHT_ARB_AUTO_OFF_EN
  // Lamp FSM with auto-off: a grant toggles ON/OFF, but retriggers during WARN (including the expiry cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      light_q <= 1'b0;
      warn_q  <= 1'b0;
      timer_q <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_OFF: begin
          if (gnt_vld_s) begin
            state_q <= ST_ON;
            light_q <= 1'b1;
            timer_q <= CNT_W'(TIMEOUT - 1);
          end
        end
        ST_ON: begin
          if (gnt_vld_s) begin
            state_q <= ST_OFF;
            light_q <= 1'b0;
            timer_q <= {CNT_W{1'b0}};
          end else if (timer_q == CNT_W'(WARN_CYC)) begin
            state_q <= ST_WARN;
            warn_q  <= 1'b1;
            timer_q <= timer_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            timer_q <= timer_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_WARN: begin
          if (gnt_vld_s) begin
            state_q <= ST_ON;
            warn_q  <= 1'b0;
            timer_q <= CNT_W'(TIMEOUT - 1);
          end else if (timer_q == {CNT_W{1'b0}}) begin
            state_q <= ST_OFF;
            light_q <= 1'b0;
            warn_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q <= ST_OFF;
          light_q <= 1'b0;
          warn_q  <= 1'b0;
          timer_q <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign warn = warn_q;
`else
  // Lamp FSM without a timer: each grant toggles between OFF and ON.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      light_q <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (gnt_vld_s) begin
            state_q <= ST_ON;
            light_q <= 1'b1;
          end
        end
        ST_ON: begin
          if (gnt_vld_s) begin
            state_q <= ST_OFF;
            light_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_OFF;
          light_q <= 1'b0;
        end
      endcase
    end
  end

  assign warn = 1'b0;
`endif

  assign light = light_q;
  assign grant = grant_q;
  assign owner = owner_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_light_arbiter_ctrl.sv
// Self-checking bench for light_arbiter_ctrl. A per-cycle behavioural model
// (sample history, pending set, modulo round-robin, lamp on-age) is checked
// against every DUT output. Directed sections pin the model with literal
// expectations. A randomized phase follows.
module tb_light_arbiter_ctrl;
  localparam int N        = 4;
  localparam int TIMEOUT  = 20;
  localparam int WARN_CYC = 5;
  localparam int CNT_W    = 16;
  localparam int HMAX     = 16384;

  logic         clk, rst;
  logic [N-1:0] btn;
  logic         light, warn;
  logic [N-1:0] grant, pend;
  logic [2:0]   owner;

  int n_checks = 0;
  int n_errors = 0;
  bit done = 1'b0;

  // reference model state
  logic [N-1:0] hist [0:HMAX-1];
  int           cyc;
  logic [N-1:0] m_pend, m_grant;
  int           m_ptr, m_owner, m_on_edge;
  bit           m_on, m_light, m_warn;

  light_arbiter_ctrl #(.N(N), .TIMEOUT(TIMEOUT), .WARN_CYC(WARN_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .btn(btn), .light(light), .warn(warn),
    .grant(grant), .owner(owner), .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one rising clock edge.
  task automatic model_step();
    logic [N-1:0] edges;
    int gidx;
    int idx;
`ifdef LIGHT_ARB_AUTO_OFF_EN
    int age_pre;
    int age;
    bit lit_pre;
    bit warn_pre;
`endif
    cyc++;
    if (!rst) begin
      hist[cyc] = '0; hist[cyc-1] = '0; hist[cyc-2] = '0;
      m_pend = '0; m_grant = '0; m_ptr = 0; m_owner = 0;
      m_on = 1'b0; m_light = 1'b0; m_warn = 1'b0;
    end else begin
      hist[cyc] = btn;
      // A rise that was sampled two edges ago becomes pending on this edge.
      edges = hist[cyc-2] & ~hist[cyc-3];
      gidx = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (gidx < 0 && m_pend[idx]) gidx = idx;
      end
      m_grant = '0;
      if (gidx >= 0) begin
        m_grant[gidx] = 1'b1;
        m_owner = gidx;
        m_ptr = (gidx + 1) % N;
      end
      m_pend = (m_pend & ~m_grant) | edges;
`ifdef LIGHT_ARB_AUTO_OFF_EN
      age_pre  = cyc - 1 - m_on_edge;
      lit_pre  = m_on && (age_pre < TIMEOUT);
      warn_pre = lit_pre && (age_pre >= TIMEOUT - WARN_CYC);
      if (gidx >= 0) begin
        if (lit_pre && !warn_pre) m_on = 1'b0;
        else begin m_on = 1'b1; m_on_edge = cyc; end
      end
      age     = cyc - m_on_edge;
      m_light = m_on && (age < TIMEOUT);
      m_warn  = m_light && (age >= TIMEOUT - WARN_CYC);
`else
      if (gidx >= 0) m_on = !m_on;
      m_light = m_on;
      m_warn  = 1'b0;
`endif
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    cyc = 3;
    for (int i = 0; i < HMAX; i++) hist[i] = '0;
    m_pend = '0; m_grant = '0; m_ptr = 0; m_owner = 0; m_on_edge = 0;
    m_on = 1'b0; m_light = 1'b0; m_warn = 1'b0;
    while (!done) begin
      @(posedge clk);
      model_step();
      #2;
      check("model_grant", 32'(grant), 32'(m_grant));
      check("model_pend",  32'(pend),  32'(m_pend));
      check("model_light", 32'(light), 32'(m_light));
      check("model_warn",  32'(warn),  32'(m_warn));
      check("model_owner", 32'(owner), 32'(m_owner));
    end
  end

  task automatic drive(input logic [N-1:0] b);
    @(negedge clk);
    btn = b;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int cnt_l, cnt_w, first_w;
    logic [N-1:0] flip;
    rst = 1'b0;
    btn = '0;

    // Reset held while switches toggle
    for (int i = 0; i < 8; i++) begin
      drive(N'($urandom));
      step(1);
      check("rst_pend",  32'(pend),  32'h0);
      check("rst_light", 32'(light), 32'h0);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_warn",  32'(warn),  32'h0);
    end
    @(negedge clk); btn = '0; rst = 1'b1;
    step(4);

    // First press after reset: served at t+3
    drive(4'b0001);
    step(3);
    check("first_grant_t2", 32'(grant), 32'h0);
    check("first_pend_t2",  32'(pend),  32'h1);
    step(1);
    check("first_grant_t3", 32'(grant), 32'h1);
    check("first_light_t3", 32'(light), 32'h1);
    check("first_owner_t3", 32'(owner), 32'h0);

`ifdef LIGHT_ARB_AUTO_OFF_EN
    // Auto-off: 20 cycles lit, the last 5 in WARN
    cnt_l = 0; cnt_w = 0; first_w = -1;
    for (int i = 0; i < 30; i++) begin
      if (light) cnt_l++;
      if (warn) begin
        cnt_w++;
        if (first_w < 0) first_w = i;
      end
      step(1);
    end
    check("auto_light_cycles", 32'(cnt_l), 32'd20);
    check("auto_warn_cycles",  32'(cnt_w), 32'd5);
    check("auto_warn_rise",    32'(first_w), 32'd15);
    check("auto_light_end",    32'(light), 32'h0);
    check("auto_warn_end",     32'(warn),  32'h0);
`else
    // No timer: lamp stays on for 10x TIMEOUT, then a second press turns it off
    cnt_l = 0; cnt_w = 0;
    for (int i = 0; i < 10 * TIMEOUT; i++) begin
      if (light) cnt_l++;
      if (warn) cnt_w++;
      step(1);
    end
    check("hold_light_cycles", 32'(cnt_l), 32'd200);
    check("hold_warn_cycles",  32'(cnt_w), 32'd0);
    drive('0);
    step(2);
    drive(4'b0001);
    step(4);
    check("toggle_grant", 32'(grant), 32'h1);
    check("toggle_light", 32'(light), 32'h0);
`endif

    // Simultaneous presses after a fresh reset (ptr=0)
    @(negedge clk); btn = '0; rst = 1'b0;
    step(3);
    @(negedge clk); rst = 1'b1;
    step(3);
    drive(4'b1111);
    step(4);
    check("sim_grant0", 32'(grant), 32'h1);
    check("sim_light0", 32'(light), 32'h1);
    step(1);
    check("sim_grant1", 32'(grant), 32'h2);
    check("sim_light1", 32'(light), 32'h0);
    step(1);
    check("sim_grant2", 32'(grant), 32'h4);
    check("sim_light2", 32'(light), 32'h1);
    step(1);
    check("sim_grant3", 32'(grant), 32'h8);
    check("sim_light3", 32'(light), 32'h0);
    check("sim_owner3", 32'(owner), 32'h3);
    step(1);
    check("sim_grant_idle", 32'(grant), 32'h0);
    check("sim_pend_idle",  32'(pend),  32'h0);

    // Round-robin fairness: after ch2, ch3 goes before ch0
    drive('0);
    step(2);
    drive(4'b0100);
    step(4);
    check("rr_grant_ch2", 32'(grant), 32'h4);
    drive('0);
    step(2);
    drive(4'b1001);
    step(4);
    check("rr_grant_ch3", 32'(grant), 32'h8);
    step(1);
    check("rr_grant_ch0", 32'(grant), 32'h1);
    check("rr_owner_ch0", 32'(owner), 32'h0);

    // Re-press of ch0 landing on its own grant cycle
    drive('0);
    step(2);
    drive(4'b0011);
    drive(4'b0010);
    drive(4'b0011);
    step(2);
    check("coll_grant_ch1", 32'(grant), 32'h2);
    step(1);
    check("coll_grant_ch0", 32'(grant), 32'h1);
    check("coll_pend_kept", 32'(pend),  32'h1);
    step(1);
    check("coll_regrant_ch0", 32'(grant), 32'h1);
    check("coll_pend_clear",  32'(pend),  32'h0);
    step(1);
    check("coll_held_no_edge", 32'(grant), 32'h0);

`ifdef LIGHT_ARB_AUTO_OFF_EN
    // Press landing on the expiry cycle retriggers a full period
    drive('0);
    step(30);
    drive(4'b0100);
    step(4);
    check("retrig_on_light", 32'(light), 32'h1);
    drive('0);
    step(16);
    drive(4'b0100);
    step(3);
    check("retrig_pre_warn",  32'(warn),  32'h1);
    check("retrig_pre_light", 32'(light), 32'h1);
    step(1);
    check("retrig_grant", 32'(grant), 32'h4);
    check("retrig_light", 32'(light), 32'h1);
    check("retrig_warn",  32'(warn),  32'h0);
    drive('0);
    step(19);
    check("retrig_last_on", 32'(light), 32'h1);
    step(1);
    check("retrig_off",     32'(light), 32'h0);
`endif

    // Randomized traffic with occasional mid-run resets
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
      end
      flip = '0;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, (it < 1500) ? 3 : 23) == 0) flip[b] = 1'b1;
      end
      btn = btn ^ flip;
    end

    step(2);
    done = 1'b1;
    step(1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
